// File: rtl/i2c_write_master_if.sv
// i2c_write_master_if: request/status handshake between the configuration
// sequencer and the I2C write master.
//   I2C_DATA [23:0]  {slave addr+W, sub-address, data} presented with GO
//   GO              request level; a 0->1 transition starts a transfer
//   END             1 = idle/complete, 0 = transfer in progress
//   ACK             1 = at least one NACK seen in the last transfer
// Modports: master (the I2C write master), slave (the requesting sequencer).
interface i2c_write_master_if;
    logic [23:0] I2C_DATA;
    logic        GO;
    logic        END;
    logic        ACK;

    modport master (
        input  I2C_DATA,
        input  GO,
        output END,
        output ACK
    );

    modport slave (
        output I2C_DATA,
        output GO,
        input  END,
        input  ACK
    );
endinterface

// File: rtl/i2c_write_master.sv
// i2c_write_master: serialises one 24-bit {slave addr, sub-address, data}
// word per GO request onto SCL/SDA, then reports END and ACK status.
// A quarter-bit tick generator derived from the system clock paces the bus.
// Ports:
//   CLOCK_50   system clock, rising edge
//   iRST_N     asynchronous active-low reset
//   ctrl       request/status handshake (I2C_DATA, GO, END, ACK)
//   I2C_SCLK   I2C clock
//   I2C_SDAT   I2C data, open-drain (drives 0 or Z)
// Optional feature macro I2C_CLK_STRETCH_EN: SCL becomes open-drain and the
// master waits at the start of each high phase until SCL reads back high.
module i2c_write_master #(
    parameter int unsigned CLK_Freq = 50000000,
    parameter int unsigned I2C_Freq = 20000,
    parameter int unsigned QDIV     = CLK_Freq / (4 * I2C_Freq)
) (
    input  logic                 CLOCK_50,
    input  logic                 iRST_N,
    i2c_write_master_if.master   ctrl,
`ifdef I2C_CLK_STRETCH_EN
    inout  wire                  I2C_SCLK,
`else
    output logic                 I2C_SCLK,
`endif
    inout  wire                  I2C_SDAT
);

    localparam int unsigned CNT_W  = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int unsigned SLOT_W = 5;
    localparam int unsigned DATA_W = 24;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(QDIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(26);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BITS  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state,    stateNext;
    logic [1:0]        qPhase,   phaseNext;
    logic [SLOT_W-1:0] slot,     slotNext;
    logic [CNT_W-1:0]  tickCnt,  cntNext;
    logic [DATA_W-1:0] shiftReg, shiftNext;
    logic              endReg,   endNext;
    logic              ackReg,   ackNext;
    logic              sclReg,   sclNext;
    logic              sdaLow,   sdaLowNext;
    logic              goD;
    logic [1:0]        sdaSync;
    logic              tick;
    logic              hold;
    logic              startReq;
    logic              ackSlot;
    logic              ackSlotNext;

    // Open-drain data line; a released line is pulled high externally
    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] sclSync;

    assign I2C_SCLK = sclReg ? 1'bz : 1'b0;

    // SCL readback synchroniser for detecting slave clock stretching
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            sclSync <= 2'b11;
        end else begin
            sclSync <= {sclSync[0], I2C_SCLK};
        end
    end

    // Freeze the start of every high phase while a slave holds SCL low
    assign hold = (state != IDLE) && (qPhase == 2'd2) &&
                  (tickCnt == '0) && !sclSync[1];
`else
    assign I2C_SCLK = sclReg;
    assign hold     = 1'b0;
`endif

    assign ctrl.END = endReg;
    assign ctrl.ACK = ackReg;

    assign tick     = (tickCnt == CNT_LAST);
    assign startReq = ctrl.GO && !goD && (state == IDLE);

    // Slots 8, 17 and 26 are the slave acknowledge bits
    assign ackSlot     = (slot == SLOT_W'(8))     || (slot == SLOT_W'(17))     || (slot == SLOT_W'(26));
    assign ackSlotNext = (slotNext == SLOT_W'(8)) || (slotNext == SLOT_W'(17)) || (slotNext == SLOT_W'(26));

    // SDA input synchroniser and GO edge register
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            sdaSync <= 2'b11;
            goD     <= 1'b0;
        end else begin
            sdaSync <= {sdaSync[0], I2C_SDAT};
            goD     <= ctrl.GO;
        end
    end

    // State and registered outputs
    always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            qPhase   <= 2'd0;
            slot     <= '0;
            tickCnt  <= '0;
            shiftReg <= '0;
            endReg   <= 1'b1;
            ackReg   <= 1'b0;
            sclReg   <= 1'b1;
            sdaLow   <= 1'b0;
        end else begin
            state    <= stateNext;
            qPhase   <= phaseNext;
            slot     <= slotNext;
            tickCnt  <= cntNext;
            shiftReg <= shiftNext;
            endReg   <= endNext;
            ackReg   <= ackNext;
            sclReg   <= sclNext;
            sdaLow   <= sdaLowNext;
        end
    end

    // Next-state logic; bus outputs are decoded from the next state so they
    // change on the same edge as the phase they belong to
    always_comb begin
        stateNext  = state;
        phaseNext  = qPhase;
        slotNext   = slot;
        cntNext    = tickCnt;
        shiftNext  = shiftReg;
        endNext    = endReg;
        ackNext    = ackReg;
        sclNext    = 1'b1;
        sdaLowNext = 1'b0;

        if (state == IDLE) begin
            cntNext   = '0;
            phaseNext = 2'd0;
            slotNext  = '0;
            if (startReq) begin
                stateNext = START;
                shiftNext = ctrl.I2C_DATA;
                endNext   = 1'b0;
                ackNext   = 1'b0;
            end
        end else begin
            if (hold) begin
                cntNext = '0;
            end else if (tick) begin
                cntNext   = '0;
                phaseNext = qPhase + 2'd1;
                if (qPhase == 2'd3) begin
                    case (state)
                        START: begin
                            stateNext = BITS;
                            slotNext  = '0;
                        end
                        BITS: begin
                            if (!ackSlot) begin
                                shiftNext = {shiftReg[DATA_W-2:0], 1'b0};
                            end
                            if (slot == SLOT_LAST) begin
                                stateNext = STOP;
                                slotNext  = '0;
                            end else begin
                                slotNext = slot + SLOT_W'(1);
                            end
                        end
                        default: begin
                            stateNext = IDLE;
                            endNext   = 1'b1;
                        end
                    endcase
                end
            end else begin
                cntNext = tickCnt + CNT_W'(1);
            end

            // Sample the acknowledge bit on the first cycle of the last quarter
            if ((state == BITS) && ackSlot && (qPhase == 2'd3) && (tickCnt == '0)) begin
                ackNext = ackReg | sdaSync[1];
            end
        end

        case (stateNext)
            START: begin
                sclNext    = 1'b1;
                sdaLowNext = phaseNext[1];
            end
            BITS: begin
                sclNext    = phaseNext[1];
                sdaLowNext = !ackSlotNext && !shiftNext[DATA_W-1];
            end
            STOP: begin
                sclNext    = phaseNext[1];
                sdaLowNext = (phaseNext != 2'd3);
            end
            default: begin
                sclNext    = 1'b1;
                sdaLowNext = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: randomized and directed transfers against a slave
// model that decodes START/STOP and bytes off the bus and acknowledges per
// a per-byte NACK mask. Expected bytes, ACK status and END latency come from
// the transfer-level rules (three bytes, 116 quarter-bit phases plus one cycle).
module tb_i2c_write_master;

    localparam int unsigned QDIV    = 4;
    localparam int unsigned EXP_LAT = 116 * QDIV + 1;

    logic CLOCK_50 = 1'b0;
    logic iRST_N   = 1'b0;
    wire  sclW;
    wire  sdaW;

    i2c_write_master_if ctrl ();

    i2c_write_master #(
        .CLK_Freq (50000000),
        .I2C_Freq (20000),
        .QDIV     (QDIV)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .iRST_N   (iRST_N),
        .ctrl     (ctrl),
        .I2C_SCLK (sclW),
        .I2C_SDAT (sdaW)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Bus pull-up and slave acknowledge driver
    logic slaveLow = 1'b0;
    pullup (sdaW);
    assign sdaW = slaveLow ? 1'b0 : 1'bz;

    int checkCnt = 0;
    int errCnt   = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: watches the bus between clock edges
    logic [7:0] rxBytes[$];
    logic [2:0] nackMask = 3'b000;
    int         startCnt = 0;
    int         stopCnt  = 0;
    logic       prevScl  = 1'b1;
    logic       prevSda  = 1'b1;
    logic       inFrame  = 1'b0;
    int         bitCnt   = 0;
    int         byteIdx  = 0;
    logic [7:0] shiftIn  = '0;

    always @(negedge CLOCK_50) begin
        logic sNow;
        logic sclNow;
        sNow   = sdaW;
        sclNow = sclW;
        if (sclNow && prevScl && prevSda && !sNow) begin
            inFrame  = 1'b1;
            bitCnt   = 0;
            byteIdx  = 0;
            slaveLow = 1'b0;
            startCnt++;
        end else if (sclNow && prevScl && !prevSda && sNow) begin
            inFrame  = 1'b0;
            slaveLow = 1'b0;
            stopCnt++;
        end else if (inFrame) begin
            if (sclNow && !prevScl) begin
                if (bitCnt < 8) shiftIn = {shiftIn[6:0], sNow};
                bitCnt++;
            end else if (!sclNow && prevScl) begin
                if (bitCnt == 8) begin
                    rxBytes.push_back(shiftIn);
                    slaveLow = (byteIdx < 3) ? !nackMask[byteIdx] : 1'b0;
                end else if (bitCnt == 9) begin
                    slaveLow = 1'b0;
                    bitCnt   = 0;
                    byteIdx++;
                end
            end
        end
        prevScl = sclNow;
        prevSda = sNow;
    end

    task automatic runXfer(input logic [23:0] data, input logic [2:0] nack,
                           input bit chgData, input bit pulseGo, input int holdCyc);
        int         cyc;
        int         starts0;
        int         stops0;
        int         endLow;
        logic [7:0] expB [3];
        logic [7:0] gotB;
        expB[0] = data[23:16];
        expB[1] = data[15:8];
        expB[2] = data[7:0];
        nackMask = nack;
        ctrl.GO  = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        rxBytes.delete();
        starts0 = startCnt;
        stops0  = stopCnt;
        ctrl.I2C_DATA = data;
        ctrl.GO       = 1'b1;
        @(posedge CLOCK_50);
        #1;
        cyc = 1;
        checkVal("end_fall", 32'(ctrl.END), 32'd0);
        if (chgData) ctrl.I2C_DATA = 24'h40FFFF;
        while (ctrl.END !== 1'b1 && cyc < 2000) begin
            if (pulseGo && cyc == 100) ctrl.GO = 1'b0;
            if (pulseGo && cyc == 103) ctrl.GO = 1'b1;
            @(posedge CLOCK_50);
            #1;
            cyc++;
        end
        checkVal("latency", 32'(cyc), 32'(EXP_LAT));
        checkVal("ack", 32'(ctrl.ACK), 32'(|nack));
        checkVal("nbytes", 32'(rxBytes.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            gotB = (i < rxBytes.size()) ? rxBytes[i] : ~expB[i];
            checkVal($sformatf("byte%0d", i), 32'(gotB), 32'(expB[i]));
        end
        checkVal("stops", 32'(stopCnt - stops0), 32'd1);
        endLow = 0;
        repeat (holdCyc) begin
            @(posedge CLOCK_50);
            #1;
            if (ctrl.END !== 1'b1) endLow++;
        end
        checkVal("no_retrigger_end", 32'(endLow), 32'd0);
        checkVal("starts", 32'(startCnt - starts0), 32'd1);
        ctrl.GO = 1'b0;
    endtask

    initial begin
        int         cyc;
        logic [23:0] rData;
        ctrl.GO       = 1'b0;
        ctrl.I2C_DATA = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkVal("rst_end", 32'(ctrl.END), 32'd1);
        checkVal("rst_ack", 32'(ctrl.ACK), 32'd0);
        checkVal("rst_scl", 32'(sclW), 32'd1);
        checkVal("rst_sda", 32'(sdaW), 32'd1);
        iRST_N = 1'b1;
        repeat (2) @(posedge CLOCK_50);

        // Directed transfers from the test plan
        runXfer(24'h340017, 3'b000, 1'b0, 1'b0, 20);
        runXfer(24'h340017, 3'b010, 1'b0, 1'b0, 20);
        runXfer(24'h340017, 3'b000, 1'b0, 1'b0, 1000);
        runXfer(24'h340017, 3'b000, 1'b0, 1'b1, 50);
        runXfer(24'h340017, 3'b000, 1'b1, 1'b0, 20);

        // Randomized transfers
        for (int i = 0; i < 6; i++) begin
            runXfer(24'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20);
        end

        // Reset in slot 12 of a transfer whose first byte is NACKed
        rData    = 24'($urandom);
        nackMask = 3'b001;
        @(posedge CLOCK_50);
        #1;
        ctrl.I2C_DATA = rData;
        ctrl.GO       = 1'b1;
        cyc = 0;
        while (cyc < 16 + 12 * 4 * QDIV + 6) begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
        end
        checkVal("pre_rst_end", 32'(ctrl.END), 32'd0);
        checkVal("pre_rst_ack", 32'(ctrl.ACK), 32'd1);
        #1;
        iRST_N = 1'b0;
        #1;
        checkVal("mid_rst_scl", 32'(sclW), 32'd1);
        checkVal("mid_rst_sda", 32'(sdaW), 32'd1);
        checkVal("mid_rst_end", 32'(ctrl.END), 32'd1);
        checkVal("mid_rst_ack", 32'(ctrl.ACK), 32'd0);
        ctrl.GO = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        iRST_N = 1'b1;
        runXfer(24'h340017, 3'b000, 1'b0, 1'b0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Single-clock I2C write master that serialises one 24-bit word {slave address, sub-address, data} per request onto SCL/SDA.
- Sits directly downstream of the codec/video-decoder configuration sequencer and consumes its DATA/GO requests.
- Returns END and ACK status to that sequencer.
- Runs on the 50 MHz system clock with an internal quarter-bit tick generator, so the requester needs no derived slow clock.

Parameters:
- CLK_Freq, 50000000, system clock frequency in Hz.
- I2C_Freq, 20000, SCL frequency in Hz.
- QDIV, CLK_Freq/(4*I2C_Freq), system cycles per quarter-bit phase. Must be >= 2.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- iRST_N  in  1  asynchronous active-low reset.
- I2C_DATA  in  24  [23:16] slave addr+W, [15:8] sub-address, [7:0] data.
- GO  in  1  request level; a 0->1 transition starts a transfer.
- END  out  1  high = idle/complete; low while a transfer is in progress.
- ACK  out  1  high = at least one NACK seen in the last transfer; low = all three bytes acknowledged.
- I2C_SCLK  out  1  I2C clock.
- I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or Z only.

Behaviour:
- Interface: one clock CLOCK_50; reset iRST_N is asynchronous, active-low.
- Reset values: I2C_SCLK=1, I2C_SDAT=Z, END=1, ACK=0, state IDLE, tick counter 0, GO edge register 0. All take effect immediately on assertion, including mid-transfer; a partial bus transaction is abandoned.
- Tick: counter 0..QDIV-1 counts only outside IDLE and wraps to 0; tick = (count==QDIV-1). Each phase Q0..Q3 lasts QDIV cycles.
- GO edge: register GO each cycle. A start occurs when GO=1, GO_d=0 and state=IDLE. On that edge:
  - latch I2C_DATA into a 24-bit shift register;
  - set END=0 and ACK=0;
  - enter START.
  The requester therefore sees END=0 on the first cycle after it raises GO.
- GO falling, or GO rising again, while busy: ignored; the edge is lost. GO held high after completion does not retrigger.
- States: IDLE -> START -> BITS -> STOP -> IDLE.
- START:
  - Q0-Q1: SCL=1, SDA=Z.
  - Q2-Q3: SCL=1, SDA=0.
- BITS: 27 slots, indexed 0..26. Slots 8, 17 and 26 are ACK slots; the others carry data MSB-first from [23] down to [0].
  - Q0: SCL=0; SDA updated (0 -> drive 0, 1 -> Z; ACK slots -> Z).
  - Q1: SCL=0.
  - Q2: SCL=1.
  - Q3: SCL=1. In ACK slots, sample SDA on the first cycle of Q3; a sampled 1 sets ACK (sticky until the next start).
- NACK does not abort the transfer; all 27 slots and STOP always complete.
- STOP:
  - Q0-Q1: SCL=0, SDA=0.
  - Q2: SCL=1, SDA=0.
  - Q3: SCL=1, SDA=Z.
  - On the last cycle of Q3, return to IDLE and set END=1 on the following cycle.
- Latency from GO rising to END rising = 116 quarters = 116*QDIV cycles, plus 1 cycle.
- I2C_DATA changes after acceptance: no effect on the transfer.
- SDA input (ACK sampling) passes through a 2-flop synchroniser before use.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined:
  - I2C_SCLK is open-drain (drives 0 or Z).
  - On entry to Q2 of any START/BITS/STOP phase, the tick counter holds at 0 while the synchronised SCL input reads 0 (slave stretching).
  - Q2 begins counting once SCL reads 1.
- Undefined:
  - I2C_SCLK is driven push-pull 0/1.
  - No SCL readback is performed; timing is exactly 116*QDIV cycles.

Test Plan:
- Parameters QDIV=4, slave model ACKs all bytes. GO 0->1 with I2C_DATA=24'h340017 -> END falls next cycle. SDA bit stream 0x34,A,0x00,A,0x17,A between START and STOP. END rises 465 cycles after GO; ACK=0.
- Same stimulus, slave NACKs the second byte only -> ACK=1 at END. The third byte and STOP are still emitted.
- GO held high for 1000 cycles after completion -> exactly one transfer. GO pulsed 0->1 mid-transfer -> ignored, still one transfer.
- iRST_N asserted during slot 12 -> same cycle: SCLK=1, SDA=Z, END=1, ACK=0. After release, a new GO gives a clean transfer.
- I2C_DATA changed to 24'h40FFFF one cycle after GO -> bus still carries 0x34/0x00/0x17.
- I2C_CLK_STRETCH_EN defined, slave holds SCL low 20 cycles in slot 3 -> END rises 20 cycles later than nominal. Bit values unchanged.
